// File: rtl/uart_boot_loader_if.sv
// Bundle of the loader's rx-buffer, imem, UART TX and core-side signals.
// master: the loader drives its outputs; slave: the surrounding system / bench.
interface uart_boot_loader_if #(
  parameter int ADDR_WIDTH = 14
);
  logic [7:0]            rx_rdata;
  logic                  rx_ready;
  logic                  rx_next;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic [7:0]            tx_data;
  logic                  tx_start;
  logic                  tx_busy;
  logic                  core_rstn;
  logic [7:0]            core_rdata;
  logic                  core_rx_ready;
  logic                  core_next;
  logic                  load_err;

  modport master (
    input  rx_rdata, rx_ready, tx_busy, core_next,
    output rx_next, imem_we, imem_addr, imem_wdata, tx_data, tx_start,
           core_rstn, core_rdata, core_rx_ready, load_err
  );

  modport slave (
    output rx_rdata, rx_ready, tx_busy, core_next,
    input  rx_next, imem_we, imem_addr, imem_wdata, tx_data, tx_start,
           core_rstn, core_rdata, core_rx_ready, load_err
  );
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: pulls a length-prefixed big-endian word image out of the
// rx byte buffer, writes it into instruction memory, sends an ack byte, then
// releases the core and hands the rx buffer over to it.
// Optional macro LOADER_CHECKSUM_EN: a trailing XOR checksum byte is required
// after the image; a mismatch ends in the error state.
module uart_boot_loader #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [7:0]  ACK_BYTE   = 8'hAA
) (
  input  logic                   clk,
  input  logic                   rstn,
  uart_boot_loader_if.master     bus
);

  typedef enum logic [2:0] {
    S_LEN, S_DATA, S_ACK, S_RUN, S_ERR
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  // Largest accepted image length in words, one bit wider than the length field.
  localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_WIDTH;

  state_t                state;
  logic [23:0]           shreg;      // the three bytes preceding the current one
  logic [1:0]            byte_cnt;
  logic [ADDR_WIDTH-1:0] word_cnt;
  logic [ADDR_WIDTH-1:0] last_idx;   // index of the final word (len-1)
  logic                  pop_prev;
  logic                  imem_we_r;
  logic [ADDR_WIDTH-1:0] imem_addr_r;
  logic [31:0]           imem_wdata_r;
  logic [7:0]            tx_data_r;
  logic                  tx_start_r;
  logic                  core_rstn_r;
  logic                  load_err_r;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  logic        loading;
  logic        pop;
  logic        run;
  logic [31:0] word_in;

  // Loader pops only in byte-consuming states, never twice in a row, so a
  // lagging rx_ready flag after a pop cannot consume the same byte again.
  always_comb begin
    loading = (state == S_LEN) || (state == S_DATA);
`ifdef LOADER_CHECKSUM_EN
    loading = loading || (state == S_CSUM);
`endif
    run     = (state == S_RUN);
    pop     = loading && bus.rx_ready && !pop_prev;
    word_in = {shreg, bus.rx_rdata};
  end

  assign bus.rx_next       = run ? bus.core_next : pop;
  assign bus.core_rdata    = run ? bus.rx_rdata : 8'h00;
  assign bus.core_rx_ready = run & bus.rx_ready;
  assign bus.imem_we       = imem_we_r;
  assign bus.imem_addr     = imem_addr_r;
  assign bus.imem_wdata    = imem_wdata_r;
  assign bus.tx_data       = tx_data_r;
  assign bus.tx_start      = tx_start_r;
  assign bus.core_rstn     = core_rstn_r;
  assign bus.load_err      = load_err_r;

  // Load sequencer: byte assembly, length check, imem writes, ack, release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_LEN;
      shreg        <= '0;
      byte_cnt     <= '0;
      word_cnt     <= '0;
      last_idx     <= '0;
      pop_prev     <= 1'b0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= '0;
      imem_wdata_r <= '0;
      tx_data_r    <= '0;
      tx_start_r   <= 1'b0;
      core_rstn_r  <= 1'b0;
      load_err_r   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      pop_prev   <= pop;
      imem_we_r  <= 1'b0;
      tx_start_r <= 1'b0;
      if (pop) begin
        shreg    <= word_in[23:0];
        byte_cnt <= byte_cnt + 2'd1;
      end
      case (state)
        S_LEN: begin
          if (pop && byte_cnt == 2'd3) begin
            if (word_in == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state <= S_CSUM;
`else
              state <= S_ACK;
`endif
            end else if ({1'b0, word_in} > MAX_WORDS) begin
              state <= S_ERR;
            end else begin
              last_idx <= word_in[ADDR_WIDTH-1:0] - 1'b1;
              word_cnt <= '0;
              state    <= S_DATA;
            end
          end
        end
        S_DATA: begin
          // The write cycle never coincides with a pop (pop_prev is high then),
          // so the state change waits until the last word is actually written.
          if (imem_we_r) begin
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == last_idx) begin
`ifdef LOADER_CHECKSUM_EN
              state <= S_CSUM;
`else
              state <= S_ACK;
`endif
            end
          end else if (pop) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ bus.rx_rdata;
`endif
            if (byte_cnt == 2'd3) begin
              imem_we_r    <= 1'b1;
              imem_addr_r  <= word_cnt;
              imem_wdata_r <= word_in;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (pop) begin
            state <= (bus.rx_rdata == csum) ? S_ACK : S_ERR;
          end
        end
`endif
        S_ACK: begin
          if (!bus.tx_busy) begin
            tx_data_r  <= ACK_BYTE;
            tx_start_r <= 1'b1;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          core_rstn_r <= 1'b1;
        end
        S_ERR: begin
          load_err_r <= 1'b1;
        end
        default: state <= S_LEN;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: table of images plus hand sequences
// for ack back-pressure, run-mode pass-through and reset in mid-load.
module tb_uart_boot_loader;
  localparam int AW = 14;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_boot_loader_if #(.ADDR_WIDTH(AW)) bus();

  uart_boot_loader #(.ADDR_WIDTH(AW), .ACK_BYTE(8'hAA)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Rx byte FIFO model: bench pushes, DUT pops via rx_next.
  logic [7:0] fifo_mem [0:255];
  int   wr_ptr   = 0;
  int   rd_ptr   = 0;
  logic fifo_clr = 1'b0;
  assign bus.rx_ready = (rd_ptr != wr_ptr);
  assign bus.rx_rdata = fifo_mem[rd_ptr[7:0]];

  // FIFO read pointer advances on every pop strobe.
  always @(posedge clk) begin
    if (fifo_clr) rd_ptr <= 0;
    else if (bus.rx_next) rd_ptr <= rd_ptr + 1;
  end

  // Monitor: records imem writes, tx starts and the core release cycle.
  int          cyc = 0, wr_n = 0, tx_n = 0, tx_cyc = 0, crst_cyc = 0;
  logic [AW-1:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  logic [7:0]  tx_byte = 8'h00;
  logic        crst_prev = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.imem_we) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] <= bus.imem_addr;
        wr_data[wr_n] <= bus.imem_wdata;
      end
      wr_n <= wr_n + 1;
    end
    if (bus.tx_start) begin
      tx_n    <= tx_n + 1;
      tx_cyc  <= cyc;
      tx_byte <= bus.tx_data;
    end
    crst_prev <= bus.core_rstn;
    if (bus.core_rstn && !crst_prev) crst_cyc <= cyc;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_word(input logic [31:0] w);
    push(w[31:24]); push(w[23:16]); push(w[15:8]); push(w[7:0]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn     = 1'b0;
    fifo_clr = 1'b1;
    wr_ptr   = 0;
    tick(2);
    fifo_clr = 1'b0;
    rstn     = 1'b1;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n;
    n = 0;
    while (!(bus.core_rstn === 1'b1 || bus.load_err === 1'b1) && n < limit) begin
      tick(1);
      n++;
    end
    if (n >= limit) check({name, " timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    string        name;
    logic [31:0]  len;
    logic [3:0][31:0] w;
    bit           err;
  } vec_t;

  vec_t vecs [0:5];

  initial begin
    int base_wr, base_tx, fall, nw;
    logic [7:0] x;
    for (int i = 0; i < 256; i++) fifo_mem[i] = 8'h00;
    bus.tx_busy   = 1'b0;
    bus.core_next = 1'b0;

    vecs[0].name = "two_words";  vecs[0].len = 32'd2;          vecs[0].err = 1'b0;
    vecs[0].w[0] = 32'hDEADBEEF; vecs[0].w[1] = 32'h01020304;
    vecs[1].name = "len_zero";   vecs[1].len = 32'd0;          vecs[1].err = 1'b0;
    vecs[2].name = "len_4001";   vecs[2].len = 32'h00004001;   vecs[2].err = 1'b1;
    vecs[3].name = "three_words"; vecs[3].len = 32'd3;         vecs[3].err = 1'b0;
    vecs[3].w[0] = 32'h11223344; vecs[3].w[1] = 32'h00000000; vecs[3].w[2] = 32'hFFFFFFFF;
    vecs[4].name = "len_max32";  vecs[4].len = 32'hFFFFFFFF;   vecs[4].err = 1'b1;
    vecs[5].name = "one_word";   vecs[5].len = 32'd1;          vecs[5].err = 1'b0;
    vecs[5].w[0] = 32'hA5C3F00F;

    // Reset state
    tick(2);
    check("rst imem_we", 32'(bus.imem_we), 32'd0);
    check("rst core_rstn", 32'(bus.core_rstn), 32'd0);
    check("rst tx_start", 32'(bus.tx_start), 32'd0);
    check("rst load_err", 32'(bus.load_err), 32'd0);
    check("rst imem_wdata", bus.imem_wdata, 32'd0);

    // Table-driven images
    for (int i = 0; i < 6; i++) begin
      do_reset();
      base_wr = wr_n;
      base_tx = tx_n;
      push_word(vecs[i].len);
      x = 8'h00;
      if (!vecs[i].err) begin
        nw = int'(vecs[i].len);
        for (int j = 0; j < nw; j++) begin
          push_word(vecs[i].w[j]);
          x = x ^ vecs[i].w[j][31:24] ^ vecs[i].w[j][23:16] ^ vecs[i].w[j][15:8] ^ vecs[i].w[j][7:0];
        end
`ifdef LOADER_CHECKSUM_EN
        push(x);
`endif
      end
      wait_done(vecs[i].name, 2000);
      tick(20);
      check({vecs[i].name, " load_err"}, 32'(bus.load_err), 32'(vecs[i].err));
      check({vecs[i].name, " core_rstn"}, 32'(bus.core_rstn), 32'(!vecs[i].err));
      check({vecs[i].name, " tx count"}, 32'(tx_n - base_tx), vecs[i].err ? 32'd0 : 32'd1);
      check({vecs[i].name, " write count"}, 32'(wr_n - base_wr), vecs[i].err ? 32'd0 : vecs[i].len);
      if (!vecs[i].err) begin
        check({vecs[i].name, " tx byte"}, 32'(tx_byte), 32'h000000AA);
        check({vecs[i].name, " release after ack"}, 32'(crst_cyc - tx_cyc), 32'd1);
        for (int j = 0; j < int'(vecs[i].len); j++) begin
          check($sformatf("%s addr%0d", vecs[i].name, j), 32'(wr_addr[base_wr + j]), 32'(j));
          check($sformatf("%s data%0d", vecs[i].name, j), wr_data[base_wr + j], vecs[i].w[j]);
        end
      end
      $display("image %s len=%h done, load_err=%0b core_rstn=%0b", vecs[i].name, vecs[i].len, bus.load_err, bus.core_rstn);
    end

    // Run-mode pass-through (DUT is in S_RUN after the last image)
    check("run rx_ready empty", 32'(bus.core_rx_ready), 32'd0);
    push(8'h55);
    #1;
    check("run core_rdata", 32'(bus.core_rdata), 32'h55);
    check("run core_rx_ready", 32'(bus.core_rx_ready), 32'd1);
    check("run rx_next idle", 32'(bus.rx_next), 32'd0);
    bus.core_next = 1'b1;
    #1;
    check("run rx_next follows", 32'(bus.rx_next), 32'd1);
    @(negedge clk);
    bus.core_next = 1'b0;
    #1;
    check("run rx_next drops", 32'(bus.rx_next), 32'd0);
    check("run popped", 32'(bus.core_rx_ready), 32'd0);
    $display("pass-through 0x55 done");

    // Ack back-pressure: tx_busy held for 100 cycles
    do_reset();
    base_tx = tx_n;
    bus.tx_busy = 1'b1;
    push_word(32'd0);
`ifdef LOADER_CHECKSUM_EN
    push(8'h00);
`endif
    tick(100);
    check("busy no tx", 32'(tx_n - base_tx), 32'd0);
    check("busy core held", 32'(bus.core_rstn), 32'd0);
    push(8'h77);
    #1;
    check("busy rx_ready hidden", 32'(bus.core_rx_ready), 32'd0);
    check("busy rdata hidden", 32'(bus.core_rdata), 32'd0);
    @(negedge clk);
    fall = cyc;
    bus.tx_busy = 1'b0;
    tick(5);
    check("busy tx count", 32'(tx_n - base_tx), 32'd1);
    check("busy tx timing", 32'(tx_cyc - fall), 32'd1);
    check("busy byte kept", 32'(bus.core_rdata), 32'h77);
    $display("ack back-pressure done, tx at +%0d", tx_cyc - fall);

    // Reset after 2 of 4 words, then full resend
    do_reset();
    base_wr = wr_n;
    push_word(32'd4);
    push_word(32'hCAFEBABE);
    push_word(32'h12345678);
    for (int n = 0; n < 500 && (wr_n - base_wr) < 2; n++) tick(1);
    check("mid writes", 32'(wr_n - base_wr), 32'd2);
    tick(2);
    rstn = 1'b0;
    #1;
    check("mid rst imem_wdata", bus.imem_wdata, 32'd0);
    check("mid rst imem_addr", 32'(bus.imem_addr), 32'd0);
    check("mid rst imem_we", 32'(bus.imem_we), 32'd0);
    check("mid rst core_rstn", 32'(bus.core_rstn), 32'd0);
    do_reset();
    base_wr = wr_n;
    push_word(32'd4);
    push_word(32'hCAFEBABE);
    push_word(32'h12345678);
    push_word(32'h9ABCDEF0);
    push_word(32'h0F1E2D3C);
`ifdef LOADER_CHECKSUM_EN
    push(8'hCA ^ 8'hFE ^ 8'hBA ^ 8'hBE ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^
         8'h9A ^ 8'hBC ^ 8'hDE ^ 8'hF0 ^ 8'h0F ^ 8'h1E ^ 8'h2D ^ 8'h3C);
`endif
    wait_done("resend", 2000);
    tick(5);
    check("resend writes", 32'(wr_n - base_wr), 32'd4);
    check("resend addr0", 32'(wr_addr[base_wr]), 32'd0);
    check("resend data0", wr_data[base_wr], 32'hCAFEBABE);
    check("resend addr3", 32'(wr_addr[base_wr + 3]), 32'd3);
    check("resend data3", wr_data[base_wr + 3], 32'h0F1E2D3C);
    check("resend core_rstn", 32'(bus.core_rstn), 32'd1);
    $display("reset mid-load and resend done");

`ifdef LOADER_CHECKSUM_EN
    // Checksum mismatch must end in the error state
    do_reset();
    base_tx = tx_n;
    push_word(32'd1);
    push_word(32'h11223344);
    push(8'h45);
    wait_done("csum bad", 500);
    tick(10);
    check("csum bad load_err", 32'(bus.load_err), 32'd1);
    check("csum bad core_rstn", 32'(bus.core_rstn), 32'd0);
    check("csum bad no tx", 32'(tx_n - base_tx), 32'd0);
    do_reset();
    push_word(32'd1);
    push_word(32'h11223344);
    push(8'h44);
    wait_done("csum ok", 500);
    tick(10);
    check("csum ok core_rstn", 32'(bus.core_rstn), 32'd1);
    check("csum ok load_err", 32'(bus.load_err), 32'd0);
    $display("checksum match/mismatch done");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sequences the buffered UART receive path (byte FIFO with rdata/rx_ready/next pop handshake) at power-up.
- Receives a program image: 4-byte length, then N 32-bit words. Writes the words into instruction memory, sends an ack byte over UART TX, then releases the core.
- After release, hands the receive path to the core unchanged; the block is the sole owner of the rx buffer pop port.

Parameters:
- ADDR_WIDTH, 14, imem word-address width; max image = 2**ADDR_WIDTH words.
- ACK_BYTE, 8'hAA, byte transmitted after a successful load.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx_rdata  in  8  head byte of rx buffer
- rx_ready  in  1  rx buffer non-empty
- rx_next  out  1  one-cycle pop strobe to rx buffer
- imem_we  out  1  imem write strobe
- imem_addr  out  ADDR_WIDTH  imem word address
- imem_wdata  out  32  imem write data
- tx_data  out  8  byte to UART TX
- tx_start  out  1  one-cycle TX start strobe
- tx_busy  in  1  UART TX busy
- core_rstn  out  1  core reset, low until load done
- core_rdata  out  8  rx byte forwarded to core
- core_rx_ready  out  1  forwarded rx_ready
- core_next  in  1  core pop request
- load_err  out  1  sticky protocol error

Behaviour:
- Async reset: state=S_LEN, all outputs 0, byte/word counters 0, shift register 0. Deassertion is sampled on the next clk edge.
- Pop rule (loader states): byte consumed when rx_ready=1 and no pop in the previous cycle. rx_next pulses 1 cycle in the same cycle. rx_ready is ignored the cycle after a pop, so a FIFO flag lag cannot double-consume a byte.
- Bytes are assembled big-endian into a 32-bit shift register: shreg <= {shreg[23:0], rx_rdata}. A 2-bit byte counter wraps 3->0.
- S_LEN: after the 4th byte, len <= shreg value.
  - len==0: go to S_ACK.
  - len > 2**ADDR_WIDTH: go to S_ERR.
  - otherwise: go to S_DATA with word counter 0.
- S_DATA: on the 4th byte of each word:
  - imem_we=1 for exactly 1 cycle (the cycle after the 4th pop), imem_addr=word counter, imem_wdata=assembled word.
  - Word counter increments. After word len-1 is written, go to S_ACK.
  - imem_addr/imem_wdata hold their last values when imem_we=0.
- S_ACK: wait for tx_busy=0. Then tx_data=ACK_BYTE and tx_start=1 for 1 cycle, then go to S_RUN. tx_data holds afterwards.
- S_RUN (terminal until reset):
  - core_rstn=1.
  - Combinational pass-through: core_rdata=rx_rdata, core_rx_ready=rx_ready, rx_next=core_next.
  - Internal pop logic disabled.
- S_ERR (terminal until reset): load_err=1, core_rstn=0, rx_next=0, no TX.
- Outside S_RUN: core_rx_ready=0, core_rdata=0, core_next ignored.
- imem_we is never asserted outside S_DATA. Address never wraps because of the length check.
- Reset mid-load: everything is discarded and the loader restarts in S_LEN. The host must resend the whole image.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word (or after the length when len==0), the block enters S_CSUM and consumes one more byte.
  - Expected byte = XOR of all data bytes received (0x00 for len==0).
  - Match: go to S_ACK. Mismatch: go to S_ERR.
- Undefined: no S_CSUM state; S_DATA goes directly to S_ACK.

Test Plan:
- Bytes 00 00 00 02, DE AD BE EF, 01 02 03 04 -> imem writes (0,0xDEADBEEF), (1,0x01020304); tx_start once with tx_data=0xAA; core_rstn rises after it; load_err=0.
- Length 00 00 00 00 -> no imem_we; ack sent; core_rstn=1.
- Length 0x00004001 (ADDR_WIDTH=14) -> S_ERR; load_err=1; core_rstn stays 0; no tx_start.
- tx_busy held 1 for 100 cycles at ack time -> tx_start asserted only in the first cycle after tx_busy falls.
- In S_RUN, push byte 0x55 into rx buffer and pulse core_next -> core_rdata=0x55, core_rx_ready=1, and rx_next follows core_next cycle-exact.
- rstn pulsed low after 2 of 4 words -> outputs 0 immediately; resent full image loads correctly from address 0.
- With LOADER_CHECKSUM_EN: image of 1 word 11 22 33 44 with checksum 0x44 -> ack; same image with checksum 0x45 -> load_err=1.
